// File: rtl/instr_mem_loader.sv
// Byte-stream loader for instruction memory: packs 4 bytes MSB-first into a word per write.
// Optional trailing XOR checksum verification when CHECKSUM_EN is defined.
`timescale 1ns/1ps

module instr_mem_loader #(
    parameter int unsigned NUM_INSTR = 3,
    parameter int unsigned IDX_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

`ifdef CHECKSUM_EN
    typedef enum logic [1:0] {StIdle, StLoad, StCheck, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;
`endif

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_INSTR - 1);

    state_e           r_state, w_state_d;
    logic [23:0]      r_shift, w_shift_d;
    logic [1:0]       r_byte_cnt, w_byte_cnt_d;
    logic [IDX_W-1:0] r_word_idx, w_word_idx_d;
    logic             r_mem_we, w_mem_we_d;
    logic [31:0]      r_mem_addr, w_mem_addr_d;
    logic [31:0]      r_mem_wdata, w_mem_wdata_d;
    logic             w_xfer;
    logic [31:0]      w_word;

`ifdef CHECKSUM_EN
    logic [31:0]      r_checksum, w_checksum_d;
    logic             r_err, w_err_d;
`endif

    // Word completes combinationally on the 4th byte so the write lands next cycle.
    assign w_word = {r_shift, in_data};
    assign w_xfer = in_valid & in_ready;

    always_comb begin
        w_state_d     = r_state;
        w_shift_d     = r_shift;
        w_byte_cnt_d  = r_byte_cnt;
        w_word_idx_d  = r_word_idx;
        w_mem_we_d    = 1'b0;
        w_mem_addr_d  = r_mem_addr;
        w_mem_wdata_d = r_mem_wdata;
`ifdef CHECKSUM_EN
        w_checksum_d  = r_checksum;
        w_err_d       = r_err;
`endif
        unique case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_state_d    = StLoad;
                    w_byte_cnt_d = 2'd0;
                    w_word_idx_d = '0;
`ifdef CHECKSUM_EN
                    w_checksum_d = 32'd0;
                    w_err_d      = 1'b0;
`endif
                end
            end
            StLoad: begin
                if (w_xfer) begin
                    w_shift_d    = w_word[23:0];
                    w_byte_cnt_d = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        w_mem_we_d    = 1'b1;
                        w_mem_addr_d  = 32'({r_word_idx, 2'b00});
                        w_mem_wdata_d = w_word;
                        w_word_idx_d  = r_word_idx + 1'b1;
`ifdef CHECKSUM_EN
                        w_checksum_d  = r_checksum ^ w_word;
                        if (r_word_idx == LastIdx) w_state_d = StCheck;
`else
                        if (r_word_idx == LastIdx) w_state_d = StDone;
`endif
                    end
                end
            end
`ifdef CHECKSUM_EN
            StCheck: begin
                if (w_xfer) begin
                    w_shift_d    = w_word[23:0];
                    w_byte_cnt_d = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        w_err_d   = (w_word != r_checksum);
                        w_state_d = StDone;
                    end
                end
            end
`endif
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_shift     <= 24'd0;
            r_byte_cnt  <= 2'd0;
            r_word_idx  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_state     <= w_state_d;
            r_shift     <= w_shift_d;
            r_byte_cnt  <= w_byte_cnt_d;
            r_word_idx  <= w_word_idx_d;
            r_mem_we    <= w_mem_we_d;
            r_mem_addr  <= w_mem_addr_d;
            r_mem_wdata <= w_mem_wdata_d;
        end
    end

`ifdef CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            r_checksum <= w_checksum_d;
            r_err      <= w_err_d;
        end
    end

    assign in_ready = (r_state == StLoad) || (r_state == StCheck);
    assign err      = r_err;
`else
    assign in_ready = (r_state == StLoad);
    assign err      = 1'b0;
`endif

    assign busy      = in_ready;
    assign done      = (r_state == StDone);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued as bytes are sent and
// popped by a write monitor. Checksum scenarios run when CHECKSUM_EN is defined.
`timescale 1ns/1ps

module tb_instr_mem_loader;

    localparam int unsigned NumInstr = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    logic prev_we = 1'b0;
    logic [63:0] exp_q[$];
    logic [7:0]  img[12];

    instr_mem_loader #(
        .NUM_INSTR(NumInstr),
        .IDX_W    (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst_n) begin
            prev_we = 1'b0;
        end else begin
            if (mem_we) begin
                wr_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write got addr=%h data=%h expected none",
                             mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({mem_addr, mem_wdata} !== e) begin
                        bad++;
                        $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                                 mem_addr, mem_wdata, e[63:32], e[31:0]);
                    end
                end
                total++;
                if (prev_we) begin
                    bad++;
                    $display("FAIL we_width got two consecutive strobes expected one");
                end
            end
            prev_we = mem_we;
        end
    end

    function automatic logic [31:0] img_word(input int w);
        return {img[4*w], img[4*w+1], img[4*w+2], img[4*w+3]};
    endfunction

    function automatic logic [31:0] img_xor();
        logic [31:0] x = 32'd0;
        for (int w = 0; w < int'(NumInstr); w++) x ^= img_word(w);
        return x;
    endfunction

    task automatic set_img(input logic [95:0] v);
        for (int i = 0; i < 12; i++) img[i] = v[95-8*i -: 8];
    endtask

    task automatic push_words(input int n);
        for (int w = 0; w < n; w++) exp_q.push_back({32'(w * 4), img_word(w)});
    endtask

    task automatic start_pulse();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL byte_accept got in_ready=0 expected 1 within 20 cycles");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_bytes(input int first, input int last, input bit toggle);
        for (int i = first; i <= last; i++) begin
            send_byte(img[i]);
            if (toggle && i < 11) begin
                @(negedge clk);
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_idle got %b expected 1", busy);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
    endtask

    task automatic finish_load();
`ifdef CHECKSUM_EN
        send_word(img_xor());
`endif
    endtask

    task automatic wait_done_and_check(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_done got done=0 expected 1", name);
        end
        @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_pending got %0d writes missing expected 0", name, exp_q.size());
        end
        total++;
        if (wr_cnt != int'(NumInstr)) begin
            bad++;
            $display("FAIL %s_count got %0d strobes expected %0d", name, wr_cnt, NumInstr);
        end
        total++;
        if ({busy, in_ready} !== 2'b00) begin
            bad++;
            $display("FAIL %s_idle got busy=%b in_ready=%b expected 0 0", name, busy, in_ready);
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({in_ready, mem_we, busy, done, err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got %b expected 00000", {in_ready, mem_we, busy, done, err});
        end
        total++;
        if ({mem_addr, mem_wdata} !== 64'd0) begin
            bad++;
            $display("FAIL reset_bus got %h %h expected 0 0", mem_addr, mem_wdata);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        start_pulse();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL start_busy got %b expected 1", busy);
        end
        send_byte(8'h12);
        send_byte(8'h34);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, busy, done, err, mem_we} !== 5'b0) begin
            bad++;
            $display("FAIL async_reset got %b expected 00000", {in_ready, busy, done, err, mem_we});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        set_img(96'h00112233_44556677_8C000001);
        wr_cnt = 0;
        push_words(NumInstr);
        start_pulse();
        send_bytes(0, 11, 1'b0);
        finish_load();
        wait_done_and_check("b2b");
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_err got %b expected 0", err);
        end
    endtask

    task automatic test_toggle();
        set_img(96'h00112233_44556677_8C000001);
        wr_cnt = 0;
        push_words(NumInstr);
        start_pulse();
        send_bytes(0, 11, 1'b1);
        finish_load();
        wait_done_and_check("toggle");
    endtask

    task automatic test_start_ignored();
        set_img(96'hA1B2C3D4_E5F60718_293A4B5C);
        wr_cnt = 0;
        push_words(NumInstr);
        start_pulse();
        send_bytes(0, 4, 1'b0);
        start_pulse();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL start_busy_ignored got %b expected 1", busy);
        end
        send_bytes(5, 11, 1'b0);
        finish_load();
        wait_done_and_check("ignore");
        // A byte offered during DONE must still be the first byte of the next load.
        set_img(96'hDEADBEEF_01020304_05060708);
        wr_cnt = 0;
        push_words(NumInstr);
        in_valid = 1'b1;
        in_data  = img[0];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({in_ready, done} !== 2'b01) begin
                bad++;
                $display("FAIL done_hold got in_ready=%b done=%b expected 0 1", in_ready, done);
            end
        end
        start_pulse();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL reload_done got %b expected 0", done);
        end
        send_bytes(0, 11, 1'b0);
        finish_load();
        wait_done_and_check("reload");
    endtask

`ifdef CHECKSUM_EN
    task automatic test_checksum(input bit good);
        set_img(96'h00112233_44556677_8C000001);
        wr_cnt = 0;
        push_words(NumInstr);
        start_pulse();
        send_bytes(0, 11, 1'b0);
        send_word(good ? img_xor() : 32'h0000_0000);
        wait_done_and_check(good ? "cks_good" : "cks_bad");
        total++;
        if (err !== !good) begin
            bad++;
            $display("FAIL checksum_err got %b expected %b", err, !good);
        end
    endtask
`endif

    task automatic test_reset_midload();
        set_img(96'h00112233_44556677_8C000001);
        wr_cnt = 0;
        push_words(1);
        start_pulse();
        send_bytes(0, 5, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({mem_we, busy, done, mem_addr, mem_wdata} !== 67'd0) begin
            bad++;
            $display("FAIL midload_reset got we=%b busy=%b done=%b addr=%h data=%h expected 0",
                     mem_we, busy, done, mem_addr, mem_wdata);
        end
        total++;
        if (wr_cnt != 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL midload_writes got %0d strobes expected 1", wr_cnt);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        test_back_to_back();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_toggle();
        test_start_ignored();
`ifdef CHECKSUM_EN
        test_checksum(1'b1);
        test_checksum(1'b0);
`endif
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
